// File: rtl/lcb_arb_pkg.sv
// Shared types, widths and the round-robin pick helper for the LCB buffer arbiter.
package lcb_arb_pkg;

    localparam int unsigned WRD_W = 12;
    localparam int unsigned ADR_W = 10;
    localparam int unsigned LCB_N = 4;
    localparam int unsigned IDX_W = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    // One requester's view of the group-buffer port
    typedef struct packed {
        logic [WRD_W-1:0] wrd;
        logic [ADR_W-1:0] addr;
        logic             wren;
        logic [ADR_W-1:0] old_addr;
        logic             old_rden;
    } lcb_req_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             valid;
    } rr_pick_t;

    // First set bit at or after ptr, wrapping; scanned far-to-near so the nearest wins
    function automatic rr_pick_t rr_pick(input logic [LCB_N-1:0] req, input logic [IDX_W-1:0] ptr);
        rr_pick_t         r;
        logic [IDX_W-1:0] i;
        r = '0;
        for (int k = LCB_N - 1; k >= 0; k--) begin
            i = ptr + IDX_W'(k);
            if (req[i]) begin
                r.idx   = i;
                r.valid = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lcb_arb_rr.sv
// Combinational round-robin picker: lowest eligible index at or after the pointer.
module lcb_arb_rr
    import lcb_arb_pkg::*;
(
    input  logic [LCB_N-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    rr_pick_t pick;

    always_comb begin
        pick = rr_pick(req, ptr);
    end

    assign idx   = pick.idx;
    assign valid = pick.valid;

endmodule

// File: rtl/lcb_buf_arbiter.sv
// Round-robin owner of the shared group-buffer port for four LCB assemblers, with
// watchdog and buf_swch guard. Optional statistics ports under LCB_ARB_STATS_EN.
module lcb_buf_arbiter
    import lcb_arb_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 4095,
    parameter int unsigned TO_W    = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       busy,
    input  logic [N_REQ*WRD_W-1:0] wrd_out,
    input  logic [N_REQ*ADR_W-1:0] wrd_addr,
    input  logic [N_REQ-1:0]       wren,
    input  logic [N_REQ*ADR_W-1:0] old_addr,
    input  logic [N_REQ-1:0]       old_rden,
    output logic [WRD_W-1:0]       old_wrd,
    input  logic [WRD_W-1:0]       comm_old_wrd,
    output logic [WRD_W-1:0]       comm_wrd_out,
    output logic [ADR_W-1:0]       comm_wrd_addr,
    output logic                   comm_wren,
    output logic [ADR_W-1:0]       comm_old_addr,
    output logic                   comm_old_rden,
    input  logic                   buf_swch,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       to_err,
    input  logic                   err_clr
`ifdef LCB_ARB_STATS_EN
    ,
    output logic [63:0]            grant_cnt,
    output logic [TO_W-1:0]        max_hold
`endif
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    arb_state_e       state;
    arb_state_e       state_nxt;
    logic [IDX_W-1:0] gidx;
    logic [IDX_W-1:0] ptr;
    logic [LCB_N-1:0] lockout;
    logic [TO_W-1:0]  wd;

    logic [LCB_N-1:0] eligible;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic             issue;
    logic             rel;
    logic             tmo;
    logic [LCB_N-1:0] tmo_vec;

    logic             sw_s1;
    logic             sw_s2;
    logic             sw_s3;
    logic             sw_edge;
    logic             guard_q;
    logic             guard;

    lcb_req_t         req_bus [LCB_N];
    lcb_req_t         sel;
    lcb_req_t         hold_q;

    // Unpack the flat per-requester buses
    always_comb begin
        for (int i = 0; i < LCB_N; i++) begin
            req_bus[i].wrd      = wrd_out[i*WRD_W +: WRD_W];
            req_bus[i].addr     = wrd_addr[i*ADR_W +: ADR_W];
            req_bus[i].wren     = wren[i];
            req_bus[i].old_addr = old_addr[i*ADR_W +: ADR_W];
            req_bus[i].old_rden = old_rden[i];
        end
    end

    assign sel      = req_bus[gidx];
    assign eligible = busy & ~lockout;

    lcb_arb_rr u_rr (
        .req   (eligible),
        .ptr   (ptr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // buf_swch is asynchronous; any edge after synchronization blocks new grants for two cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_s1   <= 1'b0;
            sw_s2   <= 1'b0;
            sw_s3   <= 1'b0;
            guard_q <= 1'b0;
        end else begin
            sw_s1   <= buf_swch;
            sw_s2   <= sw_s1;
            sw_s3   <= sw_s2;
            guard_q <= sw_edge;
        end
    end

    assign sw_edge = sw_s2 ^ sw_s3;
    assign guard   = sw_edge | guard_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; a busy drop takes precedence over a coincident timeout
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        rel       = 1'b0;
        tmo       = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid && !guard) begin
                    issue     = 1'b1;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (!busy[gidx]) begin
                    rel       = 1'b1;
                    state_nxt = RELEASE;
                end else if (wd == TO_LAST) begin
                    rel       = 1'b1;
                    tmo       = 1'b1;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign tmo_vec = tmo ? (LCB_N'(1) << gidx) : '0;

    // Owner, pointer, watchdog, lockout, error flags and the hold copy of the last mux values
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gidx    <= '0;
            grant   <= '0;
            ptr     <= '0;
            wd      <= '0;
            lockout <= '0;
            to_err  <= '0;
            hold_q  <= '0;
        end else begin
            if (issue) begin
                gidx  <= pick_idx;
                grant <= LCB_N'(1) << pick_idx;
                wd    <= '0;
            end else if (rel) begin
                grant <= '0;
                ptr   <= gidx + IDX_W'(1);
            end
            if (state == GRANT) begin
                wd     <= wd + TO_W'(1);
                hold_q <= sel;
            end
            lockout <= (lockout & busy) | tmo_vec;
            to_err  <= (err_clr ? '0 : to_err) | tmo_vec;
        end
    end

    // Mux outputs follow the registered owner; addresses/data hold outside GRANT
    always_comb begin
        comm_wrd_out  = hold_q.wrd;
        comm_wrd_addr = hold_q.addr;
        comm_old_addr = hold_q.old_addr;
        comm_wren     = 1'b0;
        comm_old_rden = 1'b0;
        if (state == GRANT) begin
            comm_wrd_out  = sel.wrd;
            comm_wrd_addr = sel.addr;
            comm_old_addr = sel.old_addr;
            comm_wren     = sel.wren;
            comm_old_rden = sel.old_rden;
        end
    end

    assign old_wrd = comm_old_wrd;

`ifdef LCB_ARB_STATS_EN
    logic [15:0]     gcnt_q [LCB_N];
    logic [TO_W-1:0] max_q;

    // Per-requester grant counts and longest hold observed at release
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LCB_N; i++) gcnt_q[i] <= '0;
            max_q <= '0;
        end else if (err_clr) begin
            for (int i = 0; i < LCB_N; i++) gcnt_q[i] <= '0;
            max_q <= '0;
        end else begin
            if (issue) gcnt_q[pick_idx] <= gcnt_q[pick_idx] + 16'd1;
            if (rel && (wd > max_q)) max_q <= wd;
        end
    end

    assign grant_cnt = {gcnt_q[3], gcnt_q[2], gcnt_q[1], gcnt_q[0]};
    assign max_hold  = max_q;
`else
    // statistics ports and counters are not built
`endif

endmodule

// File: tb/tb_lcb_buf_arbiter.sv
// Randomized and directed bench for lcb_buf_arbiter against a cycle-level behavioural model.
module tb_lcb_buf_arbiter;

    localparam int TO = 15;

    logic        clk;
    logic        reset;
    logic [3:0]  busy;
    logic [47:0] wrd_out;
    logic [39:0] wrd_addr;
    logic [3:0]  wren;
    logic [39:0] old_addr;
    logic [3:0]  old_rden;
    logic [11:0] old_wrd;
    logic [11:0] comm_old_wrd;
    logic [11:0] comm_wrd_out;
    logic [9:0]  comm_wrd_addr;
    logic        comm_wren;
    logic [9:0]  comm_old_addr;
    logic        comm_old_rden;
    logic        buf_swch;
    logic [3:0]  grant;
    logic [3:0]  to_err;
    logic        err_clr;
`ifdef LCB_ARB_STATS_EN
    logic [63:0] grant_cnt;
    logic [11:0] max_hold;
`endif

    int total = 0;
    int bad   = 0;

    // model state
    int          owner;
    bit          dead;
    int          held;
    int          m_ptr;
    logic [3:0]  m_lock;
    logic [3:0]  m_err;
    logic [11:0] l_wd;
    logic [9:0]  l_wa;
    logic [9:0]  l_oa;
    bit          sw_h [4];

    lcb_buf_arbiter #(.N_REQ(4), .TIMEOUT(TO), .TO_W(12)) dut (
        .clk           (clk),
        .reset         (reset),
        .busy          (busy),
        .wrd_out       (wrd_out),
        .wrd_addr      (wrd_addr),
        .wren          (wren),
        .old_addr      (old_addr),
        .old_rden      (old_rden),
        .old_wrd       (old_wrd),
        .comm_old_wrd  (comm_old_wrd),
        .comm_wrd_out  (comm_wrd_out),
        .comm_wrd_addr (comm_wrd_addr),
        .comm_wren     (comm_wren),
        .comm_old_addr (comm_old_addr),
        .comm_old_rden (comm_old_rden),
        .buf_swch      (buf_swch),
        .grant         (grant),
        .to_err        (to_err),
        .err_clr       (err_clr)
`ifdef LCB_ARB_STATS_EN
        ,
        .grant_cnt     (grant_cnt),
        .max_hold      (max_hold)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner  = -1;
        dead   = 0;
        held   = 0;
        m_ptr  = 0;
        m_lock = '0;
        m_err  = '0;
        l_wd   = '0;
        l_wa   = '0;
        l_oa   = '0;
        for (int i = 0; i < 4; i++) sw_h[i] = 0;
    endtask

    // One clock edge of the reference behaviour, from the inputs sampled at that edge
    task automatic model_edge();
        bit         grd;
        logic [3:0] elig;
        logic [3:0] new_err;
        int         i;
        grd     = (sw_h[1] != sw_h[2]) || (sw_h[2] != sw_h[3]);
        elig    = busy & ~m_lock;
        new_err = '0;
        if (owner < 0 && !dead) begin
            if (elig != 0 && !grd) begin
                for (int k = 0; k < 4; k++) begin
                    i = (m_ptr + k) % 4;
                    if (elig[i]) begin
                        owner = i;
                        held  = 0;
                        break;
                    end
                end
            end
        end else if (dead) begin
            dead = 0;
        end else begin
            l_wd = wrd_out[owner*12 +: 12];
            l_wa = wrd_addr[owner*10 +: 10];
            l_oa = old_addr[owner*10 +: 10];
            if (!busy[owner]) begin
                m_ptr = (owner + 1) % 4;
                owner = -1;
                dead  = 1;
            end else if (held + 1 == TO) begin
                new_err[owner] = 1'b1;
                m_ptr = (owner + 1) % 4;
                owner = -1;
                dead  = 1;
            end else begin
                held++;
            end
        end
        m_lock = (m_lock & busy) | new_err;
        m_err  = (err_clr ? 4'b0 : m_err) | new_err;
        for (int k = 3; k > 0; k--) sw_h[k] = sw_h[k-1];
        sw_h[0] = buf_swch;
    endtask

    task automatic check_outputs();
        if (owner >= 0) begin
            chk("grant", grant, 4'b0001 << owner);
            chk("comm_wren", comm_wren, wren[owner]);
            chk("comm_old_rden", comm_old_rden, old_rden[owner]);
            chk("comm_wrd_out", comm_wrd_out, wrd_out[owner*12 +: 12]);
            chk("comm_wrd_addr", comm_wrd_addr, wrd_addr[owner*10 +: 10]);
            chk("comm_old_addr", comm_old_addr, old_addr[owner*10 +: 10]);
        end else begin
            chk("grant", grant, 4'b0000);
            chk("comm_wren", comm_wren, 1'b0);
            chk("comm_old_rden", comm_old_rden, 1'b0);
            chk("comm_wrd_out", comm_wrd_out, l_wd);
            chk("comm_wrd_addr", comm_wrd_addr, l_wa);
            chk("comm_old_addr", comm_old_addr, l_oa);
        end
        chk("to_err", to_err, m_err);
        chk("old_wrd", old_wrd, comm_old_wrd);
    endtask

    task automatic cyc();
        @(posedge clk);
        if (reset) model_reset();
        else model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic rnd_data();
        wrd_out      = 48'({$urandom(), $urandom()});
        wrd_addr     = 40'({$urandom(), $urandom()});
        old_addr     = 40'({$urandom(), $urandom()});
        wren         = 4'($urandom());
        old_rden     = 4'($urandom());
        comm_old_wrd = 12'($urandom());
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        busy     = '0;
        buf_swch = 1'b0;
        err_clr  = 1'b0;
        model_reset();
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] order [$];
        logic [3:0] exp_order [5];
        logic [3:0] prev;
        int         hc;

        reset = 1'b1;
        busy = '0; wren = '0; old_rden = '0; err_clr = 1'b0; buf_swch = 1'b0;
        wrd_out = '0; wrd_addr = '0; old_addr = '0; comm_old_wrd = '0;
        model_reset();
        cyc();
        cyc();
        chk("rst_grant", grant, 4'b0000);
        chk("rst_to_err", to_err, 4'b0000);
        chk("rst_comm_wrd_out", comm_wrd_out, 12'h000);
        reset = 1'b0;
        cyc();

        // single requester 2: grant, address follow, release
        rnd_data();
        busy = 4'b0100;
        cyc();
        chk("r2_grant", grant, 4'b0100);
        chk("r2_addr", comm_wrd_addr, wrd_addr[29:20]);
        busy = 4'b0000;
        cyc();
        chk("r2_rel_wren", comm_wren, 1'b0);
        chk("r2_rel_grant", grant, 4'b0000);
        cyc();

        // all busy, rotating ownership
        do_reset();
        busy = 4'b1111;
        prev = '0;
        hc   = 0;
        repeat (75) begin
            rnd_data();
            cyc();
            if (grant != 0) begin
                if (grant != prev) begin
                    order.push_back(grant);
                    hc = 0;
                end
                hc++;
            end
            prev = grant;
            busy = 4'b1111;
            if (grant != 0 && hc == 10) busy = ~grant;
        end
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        chk("rr_count", (order.size() >= 5) ? 1 : 0, 1);
        for (int i = 0; i < 5; i++) begin
            if (i < order.size()) chk($sformatf("rr_order%0d", i), order[i], exp_order[i]);
        end

        // watchdog on requester 1
        do_reset();
        busy = 4'b0010;
        repeat (20) cyc();
        chk("tmo_err", to_err, 4'b0010);
        chk("tmo_locked", grant, 4'b0000);
        busy = 4'b0000;
        cyc();
        busy = 4'b0010;
        cyc();
        chk("tmo_regrant", grant, 4'b0010);
        busy = 4'b0000;
        cyc();
        cyc();
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        chk("tmo_clr", to_err, 4'b0000);

        // buffer-switch guard
        do_reset();
        buf_swch = 1'b1;
        cyc();
        cyc();
        busy = 4'b0001;
        cyc();
        chk("guard0", grant, 4'b0000);
        cyc();
        chk("guard1", grant, 4'b0000);
        cyc();
        chk("guard_end", grant, 4'b0001);
        buf_swch = 1'b0;
        repeat (6) cyc();
        chk("swch_in_grant", grant, 4'b0001);

        // only requester 3 owns the port while all assert wren
        do_reset();
        rnd_data();
        wren = 4'b1111;
        busy = 4'b1000;
        cyc();
        chk("r3_wren", comm_wren, 1'b1);
        chk("r3_wrd", comm_wrd_out, wrd_out[47:36]);
        wren = 4'b0111;
        #1;
        chk("r3_wren_off", comm_wren, 1'b0);
        busy = 4'b0000;
        cyc();
        cyc();

        // randomized traffic
        do_reset();
        repeat (3000) begin
            rnd_data();
            for (int i = 0; i < 4; i++) if ($urandom_range(9) == 0) busy[i] = ~busy[i];
            err_clr = ($urandom_range(49) == 0);
            if ($urandom_range(39) == 0) buf_swch = ~buf_swch;
            cyc();
        end
        err_clr = 1'b0;

        // reset in the middle of a grant restarts arbitration from pointer 0
        do_reset();
        busy = 4'b0100;
        cyc();
        chk("mid_grant", grant, 4'b0100);
        busy  = 4'b1010;
        reset = 1'b1;
        model_reset();
        #1;
        chk("mid_rst_grant", grant, 4'b0000);
        chk("mid_rst_wren", comm_wren, 1'b0);
        chk("mid_rst_wrd", comm_wrd_out, 12'h000);
        chk("mid_rst_addr", comm_wrd_addr, 10'h000);
        @(negedge clk);
        cyc();
        reset = 1'b0;
        cyc();
        chk("rst_ptr0", grant, 4'b0010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
